seg7_capture: RTL and testbench
===============================

Name: seg7_capture

Overview:
- Receive-side counterpart of the hex-to-7-segment decoder. It watches a multiplexed 7-segment display bus (one-hot active-low digit enables plus a shared segment bus) and recovers the hex value shown on each digit.
- Used as an in-system display monitor and as a self-check block beside the display driver.
- Flags segment patterns that are not legal hex glyphs, and reports when a full scan frame has been seen.

Parameters:
- N_DIG, 4, number of multiplexed digits (2..8).
- STABLE_CYC, 4, consecutive identical samples needed before a digit is captured (2..255).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- an_n  input  N_DIG  digit enables, active-low; bit k low selects digit k.
- seg  input  7  segment bus, active-high, seg[6]=a … seg[0]=g.
- digits  output  4*N_DIG  captured hex values; digit k is on digits[4k+3:4k].
- dig_valid  output  N_DIG  bit k=1 when digit k holds a legal captured glyph.
- err  output  1  one-cycle pulse when a stable pattern is not a legal glyph.
- err_dig  output  3  index of the digit that caused the last err; holds its value between errors.
- frame_done  output  1  one-cycle pulse when every digit has been captured since the previous pulse.

Behaviour:
- Reset (async, rst_n=0) clears everything to 0: digits, dig_valid, err, err_dig, frame_done, the sample registers, the previous-sample register, the stability counter and the seen mask.
- Input stage: an_n and seg are registered once (an_q, seg_q). Inputs are synchronous to clk.
- Classification of an_q:
  - Exactly one bit low at index k: active digit k.
  - All bits high: blank.
  - More than one bit low: conflict.
- Stability counter cnt, 8 bits, saturating:
  - Active digit k, and {k, seg_q} equals the previous cycle's sample: cnt <= min(cnt+1, STABLE_CYC).
  - Active digit with a different sample: cnt <= 1.
  - Blank or conflict: cnt <= 0. No capture, no err.
- Capture fires once, on the cycle cnt goes from STABLE_CYC-1 to STABLE_CYC. It does not re-fire while cnt is saturated.
  - Legal glyph: digits[k] <= hex; dig_valid[k] <= 1.
  - Illegal pattern: dig_valid[k] <= 0; digits[k] unchanged; err pulses; err_dig <= k.
- Latency: if pins are held from the sample taken at edge 0, outputs update at edge STABLE_CYC.
- Legal glyph table (seg hex -> value):
  - 7E->0, 30->1, 6D->2, 79->3, 33->4, 5B->5, 5F->6, 70->7
  - 7F->8, 7B->9, 77->A, 1F->b, 4E->C, 3D->d, 4F->E, 47->F
  - Every other value is illegal, including 00.
- Frame tracking:
  - The seen mask sets bit k on any capture of digit k, legal or illegal.
  - When the mask would become all ones, frame_done pulses on that same edge and the mask clears to 0 (the completing bit is not retained).
  - Recapturing an already-seen digit has no effect on the mask.
- Simultaneous events: err and frame_done may pulse on the same cycle; both are reported.
- Re-display of a different glyph on an already-captured digit overwrites it after STABLE_CYC cycles.
- Digit switch with an identical segment pattern still counts as a change, because k is part of the compared sample.
- Reset mid-capture discards the partial count. Capture restarts from the first sample after reset release.
- Indices k >= N_DIG cannot occur. err_dig is zero-extended from 3 bits.

Test Plan:
- Reset check: rst_n=0 for 3 cycles with random inputs -> all outputs 0. Release rst_n, drive an_n=1111 -> outputs stay 0, no pulses.
- Single capture with STABLE_CYC=4: an_n=1110, seg=6D held 4 cycles -> digits[3:0]=2 and dig_valid=0001 at edge 4. A 3-cycle hold must produce no capture.
- Full frame: scan digits 0..3 with 7E, 30, 47, 1F, each held 6 cycles -> digits=16'hBF10, dig_valid=1111. frame_done pulses exactly once, on the digit-3 capture edge; a second scan produces a second pulse.
- Illegal glyph: an_n=1011, seg=00 held 5 cycles -> err pulses exactly once, err_dig=2, dig_valid[2]=0, digits[11:8] unchanged.
- Glitch rejection: seg alternates 7F/7B every 2 cycles on digit 1 -> no capture. Conflict an_n=1100 held 10 cycles -> no capture, no err.
- Async reset mid-count: assert rst_n low after 2 stable cycles -> outputs clear immediately. After release, a fresh 4-cycle hold is required before capture.

Source files
------------

// File: rtl/seg7_capture_if.sv
// Bundle of the monitored 7-segment display pins and the recovered-value outputs.
// The display driver (or testbench) is the master; the capture block is the slave.
interface seg7_capture_if #(
  parameter int N_DIG = 4
);
  logic [N_DIG-1:0]   an_n;
  logic [6:0]         seg;
  logic [4*N_DIG-1:0] digits;
  logic [N_DIG-1:0]   dig_valid;
  logic               err;
  logic [2:0]         err_dig;
  logic               frame_done;

  modport master (
    output an_n, seg,
    input  digits, dig_valid, err, err_dig, frame_done
  );

  modport slave (
    input  an_n, seg,
    output digits, dig_valid, err, err_dig, frame_done
  );
endinterface

// File: rtl/seg7_capture.sv
// Monitors a multiplexed active-low 7-segment display bus and recovers the hex value
// shown on each digit once its pattern has been stable for STABLE_CYC samples.
module seg7_capture #(
  parameter int N_DIG      = 4,
  parameter int STABLE_CYC = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  seg7_capture_if.slave bus
);

  localparam logic [7:0] STABLE   = 8'(STABLE_CYC);
  localparam logic [7:0] STABLE_M = 8'(STABLE_CYC - 1);

  // Returns {legal, hex}; anything outside the 16 glyphs is illegal.
  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'h7E:   return {1'b1, 4'h0};
      7'h30:   return {1'b1, 4'h1};
      7'h6D:   return {1'b1, 4'h2};
      7'h79:   return {1'b1, 4'h3};
      7'h33:   return {1'b1, 4'h4};
      7'h5B:   return {1'b1, 4'h5};
      7'h5F:   return {1'b1, 4'h6};
      7'h70:   return {1'b1, 4'h7};
      7'h7F:   return {1'b1, 4'h8};
      7'h7B:   return {1'b1, 4'h9};
      7'h77:   return {1'b1, 4'hA};
      7'h1F:   return {1'b1, 4'hB};
      7'h4E:   return {1'b1, 4'hC};
      7'h3D:   return {1'b1, 4'hD};
      7'h4F:   return {1'b1, 4'hE};
      7'h47:   return {1'b1, 4'hF};
      default: return 5'h00;
    endcase
  endfunction

  logic [N_DIG-1:0]   an_q, an_d;
  logic [6:0]         seg_q, seg_d;
  logic [9:0]         prev_q, prev_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [N_DIG-1:0]   seen_q, seen_d;
  logic [4*N_DIG-1:0] digits_q, digits_d;
  logic [N_DIG-1:0]   valid_q, valid_d;
  logic               err_q, err_d;
  logic [2:0]         err_dig_q, err_dig_d;
  logic               frame_q, frame_d;

  logic [N_DIG-1:0] sel;
  logic             active;
  logic             same;
  logic             capture;
  logic [2:0]       k;
  logic [9:0]       sample;
  logic [4:0]       dec;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    an_d      = bus.an_n;
    seg_d     = bus.seg;
    digits_d  = digits_q;
    valid_d   = valid_q;
    seen_d    = seen_q;
    err_dig_d = err_dig_q;
    err_d     = 1'b0;
    frame_d   = 1'b0;
    cnt_d     = 8'd0;
    capture   = 1'b0;
    k         = 3'd0;

    sel    = ~an_q;
    active = (sel != '0) && ((sel & (sel - 1'b1)) == '0);
    for (int i = 0; i < N_DIG; i++) begin
      if (sel[i]) k = 3'(i);
    end

    // The digit index is part of the sample, so a digit switch with the same
    // segment pattern still restarts the count.
    sample = {k, seg_q};
    prev_d = sample;
    same   = (sample == prev_q);
    dec    = decode(seg_q);

    if (active) begin
      if (!same)                cnt_d = 8'd1;
      else if (cnt_q >= STABLE) cnt_d = STABLE;
      else                      cnt_d = cnt_q + 8'd1;
      capture = same && (cnt_q == STABLE_M);
    end

    for (int i = 0; i < N_DIG; i++) begin
      if (capture && sel[i]) begin
        if (dec[4]) begin
          digits_d[4*i +: 4] = dec[3:0];
          valid_d[i]         = 1'b1;
        end else begin
          valid_d[i] = 1'b0;
          err_d      = 1'b1;
          err_dig_d  = 3'(i);
        end
        seen_d[i] = 1'b1;
      end
    end

    // The completing digit is not retained: a new frame starts from an empty mask.
    if (&seen_d) begin
      frame_d = 1'b1;
      seen_d  = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_q      <= '0;
      seg_q     <= '0;
      prev_q    <= '0;
      cnt_q     <= '0;
      seen_q    <= '0;
      digits_q  <= '0;
      valid_q   <= '0;
      err_q     <= 1'b0;
      err_dig_q <= '0;
      frame_q   <= 1'b0;
    end else begin
      an_q      <= an_d;
      seg_q     <= seg_d;
      prev_q    <= prev_d;
      cnt_q     <= cnt_d;
      seen_q    <= seen_d;
      digits_q  <= digits_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      err_dig_q <= err_dig_d;
      frame_q   <= frame_d;
    end
  end

  assign bus.digits     = digits_q;
  assign bus.dig_valid  = valid_q;
  assign bus.err        = err_q;
  assign bus.err_dig    = err_dig_q;
  assign bus.frame_done = frame_q;

endmodule

// File: tb/tb_seg7_capture.sv
// Randomized and directed bench for seg7_capture against a run-length reference model
// that works directly on the pin values driven each cycle.
module tb_seg7_capture;
  localparam int N_DIG      = 4;
  localparam int STABLE_CYC = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg7_capture_if #(.N_DIG(N_DIG)) bus ();

  seg7_capture #(.N_DIG(N_DIG), .STABLE_CYC(STABLE_CYC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Glyph table indexed by hex value.
  logic [6:0] glyph [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                             7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  // Reference model state
  logic [3:0]       m_dig [N_DIG];
  bit               m_valid [N_DIG];
  bit               m_seen [N_DIG];
  bit               m_err;
  int               m_err_dig;
  bit               m_frame;
  logic [N_DIG-1:0] last_an;
  logic [6:0]       last_seg;
  int               run;
  bit               pending;
  int               p_k;
  logic [6:0]       p_seg;
  int               frame_count;
  int               err_count;

  function automatic bit lookup(input logic [6:0] s, output logic [3:0] v);
    v = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (glyph[i] == s) begin
        v = 4'(i);
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic bit single_low(input logic [N_DIG-1:0] an, output int k);
    int n = 0;
    k = 0;
    for (int i = 0; i < N_DIG; i++) begin
      if (!an[i]) begin
        n++;
        k = i;
      end
    end
    return n == 1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N_DIG; i++) begin
      m_dig[i]   = 4'h0;
      m_valid[i] = 1'b0;
      m_seen[i]  = 1'b0;
    end
    m_err     = 1'b0;
    m_err_dig = 0;
    m_frame   = 1'b0;
    last_an   = '1;
    last_seg  = '0;
    run       = 0;
    pending   = 1'b0;
  endtask

  // One clock edge: a run of STABLE_CYC identical active samples becomes visible one edge later.
  task automatic model_edge(input logic [N_DIG-1:0] an, input logic [6:0] sg);
    logic [3:0] v;
    bit all_seen;
    int k;
    m_err   = 1'b0;
    m_frame = 1'b0;
    if (pending) begin
      if (lookup(p_seg, v)) begin
        m_dig[p_k]   = v;
        m_valid[p_k] = 1'b1;
      end else begin
        m_valid[p_k] = 1'b0;
        m_err        = 1'b1;
        m_err_dig    = p_k;
      end
      m_seen[p_k] = 1'b1;
      all_seen = 1'b1;
      for (int i = 0; i < N_DIG; i++) all_seen &= m_seen[i];
      if (all_seen) begin
        m_frame = 1'b1;
        for (int i = 0; i < N_DIG; i++) m_seen[i] = 1'b0;
      end
    end
    pending = 1'b0;
    if (single_low(an, k)) run = (an == last_an && sg == last_seg) ? run + 1 : 1;
    else run = 0;
    last_an  = an;
    last_seg = sg;
    if (run == STABLE_CYC) begin
      pending = 1'b1;
      p_k     = k;
      p_seg   = sg;
    end
  endtask

  task automatic compare();
    logic [4*N_DIG-1:0] ed;
    logic [N_DIG-1:0]   ev;
    for (int i = 0; i < N_DIG; i++) begin
      ed[4*i +: 4] = m_dig[i];
      ev[i]        = m_valid[i];
    end
    check("digits", 32'(bus.digits), 32'(ed));
    check("dig_valid", 32'(bus.dig_valid), 32'(ev));
    check("err", 32'(bus.err), 32'(m_err));
    check("err_dig", 32'(bus.err_dig), 32'(m_err_dig));
    check("frame_done", 32'(bus.frame_done), 32'(m_frame));
    if (bus.frame_done) frame_count++;
    if (bus.err) err_count++;
  endtask

  task automatic cycle(input logic [N_DIG-1:0] an, input logic [6:0] sg);
    bus.an_n = an;
    bus.seg  = sg;
    @(posedge clk);
    model_edge(an, sg);
    #1;
    compare();
  endtask

  task automatic hold(input logic [N_DIG-1:0] an, input logic [6:0] sg, input int n);
    repeat (n) cycle(an, sg);
  endtask

  logic [6:0] scan_pat [4] = '{7'h7E, 7'h30, 7'h47, 7'h1F};

  initial begin
    logic [N_DIG-1:0] an;
    logic [6:0]       sg;
    int               kind;

    model_reset();
    frame_count = 0;
    err_count   = 0;

    // Reset with random pins
    rst_n = 1'b0;
    repeat (3) begin
      bus.an_n = N_DIG'($urandom);
      bus.seg  = 7'($urandom);
      @(posedge clk);
      #1;
      compare();
    end
    @(negedge clk);
    rst_n = 1'b1;
    hold(4'b1111, 7'h00, 5);

    // Short hold must not capture, full hold must
    hold(4'b1110, 7'h6D, 3);
    hold(4'b1111, 7'h00, 2);
    check("short_hold_valid", 32'(bus.dig_valid), 32'h0);
    hold(4'b1110, 7'h6D, STABLE_CYC + 1);
    check("single_dig0", 32'(bus.digits[3:0]), 32'h2);
    check("single_valid", 32'(bus.dig_valid), 32'b0001);

    // Two full scans, each completing one frame
    frame_count = 0;
    for (int d = 0; d < 4; d++) hold(~(4'b0001 << d), scan_pat[d], 6);
    check("scan_digits", 32'(bus.digits), 32'hBF10);
    check("scan_valid", 32'(bus.dig_valid), 32'hF);
    check("frame_count1", 32'(frame_count), 32'd1);
    for (int d = 0; d < 4; d++) hold(~(4'b0001 << d), scan_pat[d], 6);
    check("frame_count2", 32'(frame_count), 32'd2);

    // Illegal blank glyph on digit 2
    err_count = 0;
    hold(4'b1011, 7'h00, 6);
    check("illegal_err_count", 32'(err_count), 32'd1);
    check("illegal_err_dig", 32'(bus.err_dig), 32'd2);
    check("illegal_valid2", 32'(bus.dig_valid[2]), 32'd0);
    check("illegal_digit2", 32'(bus.digits[11:8]), 32'hF);

    // Glitchy digit 1, then a conflicting enable pattern
    for (int i = 0; i < 5; i++) begin
      hold(4'b1101, 7'h7F, 2);
      hold(4'b1101, 7'h7B, 2);
    end
    hold(4'b1100, 7'h5B, 10);
    check("glitch_digit1", 32'(bus.digits[7:4]), 32'h1);
    check("glitch_err_count", 32'(err_count), 32'd1);

    // Same pattern moving between digits restarts the count
    hold(4'b1110, 7'h33, 2);
    hold(4'b1101, 7'h33, 3);
    check("switch_digit1", 32'(bus.digits[7:4]), 32'h1);

    // Asynchronous reset in the middle of a count
    hold(4'b1110, 7'h5B, 2);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare();
    @(negedge clk);
    rst_n = 1'b1;
    hold(4'b1110, 7'h5B, STABLE_CYC);
    check("post_reset_no_capture", 32'(bus.dig_valid), 32'h0);
    cycle(4'b1110, 7'h5B);
    check("post_reset_capture", 32'(bus.digits[3:0]), 32'h5);

    // Random traffic
    for (int it = 0; it < 300; it++) begin
      kind = int'($urandom_range(0, 9));
      if (kind < 8) begin
        an = ~(N_DIG'(1) << $urandom_range(0, N_DIG - 1));
        sg = ($urandom_range(0, 6) == 0) ? 7'($urandom) : glyph[$urandom_range(0, 15)];
      end else if (kind == 8) begin
        an = '1;
        sg = 7'($urandom);
      end else begin
        do an = N_DIG'($urandom); while ($countones(~an) < 2);
        sg = 7'($urandom);
      end
      hold(an, sg, int'($urandom_range(1, 7)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
